// File: rtl/alu_core_if.sv
// rtl/alu_core_if.sv - operand/result bundle between the decode stage and the ALU
//
// Purpose: carries the opcode, both register-file operands and the immediate
//          to the ALU, and its combinational result, flags and carry back.
// Signals:
//    Operand    opcode (4 bits)
//    ReadA      register-file operand A (W bits)
//    ReadB      register-file operand B (W bits)
//    Immediate  instruction immediate (5 bits)
//    Output     combinational result (W bits)
//    Zero       Output == 0
//    Equal      ReadA == ReadB
//    CarryFlag  registered carry/borrow flag
// Modports: master drives the operands (decode side), slave is the ALU.

interface alu_core_if #(
   parameter int W = 8
);
   logic [3:0]   Operand;
   logic [W-1:0] ReadA;
   logic [W-1:0] ReadB;
   logic [4:0]   Immediate;
   logic [W-1:0] Output;
   logic         Zero;
   logic         Equal;
   logic         CarryFlag;

   modport master (
      output Operand, ReadA, ReadB, Immediate,
      input  Output, Zero, Equal, CarryFlag
   );

   modport slave (
      input  Operand, ReadA, ReadB, Immediate,
      output Output, Zero, Equal, CarryFlag
   );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - single-cycle CPU datapath ALU with a registered carry flag
//
// Purpose: computes Output from ReadA, ReadB and Immediate under a 4-bit
//          opcode. Output, Zero and Equal are combinational; only the carry
//          flag is clocked, and it feeds ADC, RLC and RRC.
// Ports:
//    Clk    system clock, carry flag updates on the rising edge
//    Reset  synchronous active-high, clears the carry flag only
//    bus    alu_core_if slave: Operand, ReadA, ReadB, Immediate in;
//           Output, Zero, Equal, CarryFlag out

module alu_core #(
   parameter int W = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   alu_core_if.slave  bus
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
      OP_XOR  = 4'd4,  OP_NOT  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,  OP_ADDI = 4'd9,  OP_ADC  = 4'd10, OP_RLC  = 4'd11,
      OP_RRC  = 4'd12, OP_PASSB = 4'd13, OP_LDI = 4'd14, OP_CMP  = 4'd15
   } op_e;

   logic         carry_q, carry_d;
   logic [W-1:0] a, b, imm, result;
   logic [2:0]   sh;
   logic [W:0]   sum_ab, diff_ab, sum_ai, sum_adc;
   logic [W:0]   shl_ext, shr_ext;
   logic         carry_out;

   always_comb begin
      a   = bus.ReadA;
      b   = bus.ReadB;
      imm = W'(bus.Immediate);
      sh  = bus.Immediate[2:0];

      sum_ab  = {1'b0, a} + {1'b0, b};
      diff_ab = {1'b0, a} - {1'b0, b};
      sum_ai  = {1'b0, a} + {1'b0, imm};
      sum_adc = sum_ab + {{W{1'b0}}, carry_q};

      // One guard bit beyond each end catches the last bit shifted out;
      // with sh == 0 the guard bit stays 0, giving carry-out 0.
      shl_ext = {1'b0, a} << sh;
      shr_ext = {a, 1'b0} >> sh;

      result    = '0;
      carry_out = carry_q;   // ops that do not touch the flag hold it

      case (bus.Operand)
         OP_ADD:   begin result = sum_ab[W-1:0];  carry_out = sum_ab[W];   end
         OP_SUB:   begin result = diff_ab[W-1:0]; carry_out = ~diff_ab[W]; end
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_NOT:   result = ~a;
         OP_SLL:   begin result = shl_ext[W-1:0]; carry_out = shl_ext[W];  end
         OP_SRL:   begin result = shr_ext[W:1];   carry_out = shr_ext[0];  end
         OP_SRA:   begin result = $signed(a) >>> sh; carry_out = shr_ext[0]; end
         OP_ADDI:  begin result = sum_ai[W-1:0];  carry_out = sum_ai[W];   end
         OP_ADC:   begin result = sum_adc[W-1:0]; carry_out = sum_adc[W];  end
         OP_RLC:   begin result = {a[W-2:0], carry_q}; carry_out = a[W-1]; end
         OP_RRC:   begin result = {carry_q, a[W-1:1]}; carry_out = a[0];   end
         OP_PASSB: result = b;
         OP_LDI:   result = imm;
         // CMP reports A on the result so Zero tests A; the flag gets no-borrow
         OP_CMP:   begin result = a;              carry_out = ~diff_ab[W]; end
         default:  begin result = '0;             carry_out = carry_q;     end
      endcase

      carry_d = Reset ? 1'b0 : carry_out;
   end

   always_ff @(posedge Clk) begin
      carry_q <= carry_d;
   end

   assign bus.Output    = result;
   assign bus.Zero      = (result == '0);
   assign bus.Equal     = (a == b);
   assign bus.CarryFlag = carry_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core

module tb_alu_core;

   logic Clk = 1'b0;
   logic Reset;
   int   tests = 0;
   int   fails = 0;
   int   mc    = 0;                 // reference carry flag
   int   cur_op, cur_a, cur_b, cur_imm;

   alu_core_if #(.W(8)) bus ();

   alu_core #(.W(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   // Reference result: {carry_out, result} from plain integer arithmetic.
   function automatic int ref_alu(input int op, input int a, input int b,
                                  input int imm, input int c);
      int r, co, sh, sa, s;
      sh = imm % 8;
      co = c;
      r  = 0;
      case (op)
         0:  begin s = a + b;     r = s % 256; co = s / 256; end
         1:  begin r = (a - b + 256) % 256; co = (a >= b) ? 1 : 0; end
         2:  r = a & b;
         3:  r = a | b;
         4:  r = a ^ b;
         5:  r = 255 - a;
         6:  begin r = (a * (1 << sh)) % 256; co = (sh == 0) ? 0 : (a >> (8 - sh)) % 2; end
         7:  begin r = a / (1 << sh); co = (sh == 0) ? 0 : (a >> (sh - 1)) % 2; end
         8:  begin
                sa = (a >= 128) ? a - 256 : a;
                r  = ((sa >>> sh) + 256) % 256;
                co = (sh == 0) ? 0 : (a >> (sh - 1)) % 2;
             end
         9:  begin s = a + imm;   r = s % 256; co = s / 256; end
         10: begin s = a + b + c; r = s % 256; co = s / 256; end
         11: begin r = (a * 2 + c) % 256; co = a / 128; end
         12: begin r = c * 128 + a / 2;   co = a % 2; end
         13: r = b;
         14: r = imm;
         default: begin r = a; co = (a >= b) ? 1 : 0; end
      endcase
      return co * 256 + r;
   endfunction

   function automatic bit ref_upd(input int op);
      return !(op inside {2, 3, 4, 5, 13, 14});
   endfunction

   task automatic drive(input int op, input int a, input int b, input int imm);
      @(negedge Clk);
      cur_op = op; cur_a = a; cur_b = b; cur_imm = imm;
      bus.Operand   = 4'(op);
      bus.ReadA     = 8'(a);
      bus.ReadB     = 8'(b);
      bus.Immediate = 5'(imm);
      #2;
   endtask

   // Clock edge, then advance the reference flag the way the spec describes.
   task automatic tick();
      int e;
      e = ref_alu(cur_op, cur_a, cur_b, cur_imm, mc);
      @(posedge Clk);
      #1;
      if (Reset)                mc = 0;
      else if (ref_upd(cur_op)) mc = e / 256;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      drive(0, 8'hFF, 8'h01, 0);
      tests++; if (bus.Output !== 8'h00 || bus.Zero !== 1'b1) begin
         fails++; $display("FAIL reset_comb: out=%h zero=%b, want 00/1", bus.Output, bus.Zero);
      end
      tick();
      tick();
      tests++; if (bus.CarryFlag !== 1'b0) begin
         fails++; $display("FAIL reset_carry: got %b want 0", bus.CarryFlag);
      end
      Reset = 1'b0;
   endtask

   task automatic test_logic();
      drive(1, 4, 4, 0);
      tests++; if (bus.Output !== 8'd0 || bus.Zero !== 1'b1 || bus.Equal !== 1'b1) begin
         fails++; $display("FAIL sub_eq: out=%h z=%b eq=%b, want 00/1/1", bus.Output, bus.Zero, bus.Equal);
      end
      tick();
      drive(2, 4, 4, 0);
      tests++; if (bus.Output !== 8'd4 || bus.Zero !== 1'b0) begin
         fails++; $display("FAIL and: out=%h z=%b, want 04/0", bus.Output, bus.Zero);
      end
      tick();
      drive(4, 4, 3, 0);
      tests++; if (bus.Output !== 8'd7 || bus.Equal !== 1'b0) begin
         fails++; $display("FAIL xor: out=%h eq=%b, want 07/0", bus.Output, bus.Equal);
      end
      tick();
      drive(3, 4, 3, 0);
      tests++; if (bus.Output !== 8'd7) begin
         fails++; $display("FAIL or: got %h want 07", bus.Output);
      end
      tick();
      drive(5, 4, 3, 0);
      tests++; if (bus.Output !== 8'hFB) begin
         fails++; $display("FAIL not: got %h want FB", bus.Output);
      end
      tick();
   endtask

   task automatic test_arith();
      Reset = 1'b1; drive(2, 0, 0, 0); tick(); Reset = 1'b0;
      drive(0, 8'hFF, 8'h01, 0);
      tests++; if (bus.Output !== 8'h00 || bus.Zero !== 1'b1) begin
         fails++; $display("FAIL add_wrap: out=%h z=%b, want 00/1", bus.Output, bus.Zero);
      end
      tick();
      tests++; if (bus.CarryFlag !== 1'b1) begin
         fails++; $display("FAIL add_carry: got %b want 1", bus.CarryFlag);
      end
      drive(10, 1, 1, 0);
      tests++; if (bus.Output !== 8'd3) begin
         fails++; $display("FAIL adc: got %h want 03", bus.Output);
      end
      tick();
      drive(1, 0, 1, 0);
      tests++; if (bus.Output !== 8'hFF) begin
         fails++; $display("FAIL sub_borrow: got %h want FF", bus.Output);
      end
      tick();
      tests++; if (bus.CarryFlag !== 1'b0) begin
         fails++; $display("FAIL sub_carry: got %b want 0", bus.CarryFlag);
      end
      drive(9, 8'h10, 0, 5'h1F);
      tests++; if (bus.Output !== 8'h2F) begin
         fails++; $display("FAIL addi: got %h want 2F", bus.Output);
      end
      tick();
      drive(14, 0, 0, 5'h15);
      tests++; if (bus.Output !== 8'h15) begin
         fails++; $display("FAIL ldi: got %h want 15", bus.Output);
      end
      tick();
      drive(13, 0, 8'hAA, 0);
      tests++; if (bus.Output !== 8'hAA) begin
         fails++; $display("FAIL passb: got %h want AA", bus.Output);
      end
      tick();
   endtask

   task automatic test_shifts();
      drive(6, 8'h81, 0, 1);
      tests++; if (bus.Output !== 8'h02) begin
         fails++; $display("FAIL sll: got %h want 02", bus.Output);
      end
      tick();
      tests++; if (bus.CarryFlag !== 1'b1) begin
         fails++; $display("FAIL sll_carry: got %b want 1", bus.CarryFlag);
      end
      drive(8, 8'h80, 0, 3);
      tests++; if (bus.Output !== 8'hF0) begin
         fails++; $display("FAIL sra3: got %h want F0", bus.Output);
      end
      tick();
      drive(8, 8'h80, 0, 7);
      tests++; if (bus.Output !== 8'hFF) begin
         fails++; $display("FAIL sra7: got %h want FF", bus.Output);
      end
      tick();
      drive(7, 8'h80, 0, 3);
      tests++; if (bus.Output !== 8'h10) begin
         fails++; $display("FAIL srl: got %h want 10", bus.Output);
      end
      tick();
      drive(6, 8'hFF, 0, 8);   // sh = 0: no shift, carry-out 0
      tests++; if (bus.Output !== 8'hFF) begin
         fails++; $display("FAIL sll0: got %h want FF", bus.Output);
      end
      tick();
      tests++; if (bus.CarryFlag !== 1'b0) begin
         fails++; $display("FAIL sll0_carry: got %b want 0", bus.CarryFlag);
      end
   endtask

   task automatic test_cmp_hold();
      drive(15, 3, 5, 0);
      tests++; if (bus.Output !== 8'd3 || bus.Zero !== 1'b0) begin
         fails++; $display("FAIL cmp: out=%h z=%b, want 03/0", bus.Output, bus.Zero);
      end
      tick();
      tests++; if (bus.CarryFlag !== 1'b0) begin
         fails++; $display("FAIL cmp_carry: got %b want 0", bus.CarryFlag);
      end
      drive(15, 0, 0, 0);
      tests++; if (bus.Output !== 8'd0 || bus.Zero !== 1'b1) begin
         fails++; $display("FAIL cmp_zero: out=%h z=%b, want 00/1", bus.Output, bus.Zero);
      end
      tick();
      // flag is now 1 (0 >= 0); AND, PASSB and LDI must leave it set
      drive(2, 0, 0, 0);  tick();
      drive(13, 0, 0, 0); tick();
      drive(14, 0, 0, 0); tick();
      tests++; if (bus.CarryFlag !== 1'b1) begin
         fails++; $display("FAIL carry_hold: got %b want 1", bus.CarryFlag);
      end
   endtask

   task automatic test_reset_mid();
      drive(0, 8'hFF, 8'h01, 0); tick();       // flag = 1
      Reset = 1'b1;
      drive(10, 1, 1, 0);
      tests++; if (bus.Output !== 8'd3) begin
         fails++; $display("FAIL adc_in_reset: got %h want 03", bus.Output);
      end
      tick();
      Reset = 1'b0;
      tests++; if (bus.CarryFlag !== 1'b0) begin
         fails++; $display("FAIL reset_mid_carry: got %b want 0", bus.CarryFlag);
      end
      drive(10, 1, 1, 0);
      tests++; if (bus.Output !== 8'd2) begin
         fails++; $display("FAIL adc_after_reset: got %h want 02", bus.Output);
      end
      tick();
   endtask

   task automatic test_random();
      int e, op, a, b, imm;
      for (int i = 0; i < 400; i++) begin
         op  = int'($urandom_range(15, 0));
         a   = int'($urandom_range(255, 0));
         b   = (i % 8 == 0) ? a : int'($urandom_range(255, 0));
         imm = int'($urandom_range(31, 0));
         drive(op, a, b, imm);
         e = ref_alu(op, a, b, imm, mc);
         tests++; if (bus.Output !== 8'(e % 256) || bus.Zero !== ((e % 256) == 0)
                      || bus.Equal !== (a == b)) begin
            fails++;
            $display("FAIL rand_comb op=%0d a=%h b=%h imm=%h c=%0d: out=%h z=%b eq=%b, want %h/%b/%b",
                     op, a, b, imm, mc, bus.Output, bus.Zero, bus.Equal,
                     8'(e % 256), (e % 256) == 0, a == b);
         end
         tick();
         tests++; if (bus.CarryFlag !== 1'(mc)) begin
            fails++; $display("FAIL rand_carry op=%0d a=%h b=%h imm=%h: got %b want %0d",
                              op, a, b, imm, bus.CarryFlag, mc);
         end
      end
   endtask

   initial begin
      Reset         = 1'b1;
      bus.Operand   = 4'd0;
      bus.ReadA     = 8'd0;
      bus.ReadB     = 8'd0;
      bus.Immediate = 5'd0;
      test_reset();
      test_logic();
      test_arith();
      test_shifts();
      test_cmp_hold();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
